botsw_fb_sequencer: RTL and testbench

- Readback end of the loop-driver bottom-switch path.
- Receives the sensed gate states of the bottom and top switches, after the driver inverter stage.
- Sequences the top and bottom enables break-before-make, with programmable dead time.
- Flags shoot-through and stuck-gate faults.
- Sits between the loop PWM logic and the XDRIVER top/bottom switch inverters.

---
 rtl/botsw_fb_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_botsw_fb_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/botsw_fb_sequencer.sv
// Break-before-make top/bottom switch sequencer with synchronized gate readback, dead-time and fault detection.
// Latency: feedback 2 cycles through the synchronizers, enables registered; no backpressure, en/pwm_in sampled every cycle.
module botsw_fb_sequencer #(
  parameter int DEAD_CYC    = 4,
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 6
) (
  input  logic       CELCLK,
  input  logic       CELRSTN,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm_in,
  input  logic       clr_fault,
  input  logic       bot_fb,
  input  logic       top_fb,
  output logic       bot_en,
  output logic       top_en,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF         = 3'b000,
    ST_DEAD_TO_BOT = 3'b001,
    ST_BOT_ON      = 3'b010,
    ST_DEAD_TO_TOP = 3'b011,
    ST_TOP_ON      = 3'b100,
    ST_FAULT       = 3'b101
  } state_e;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_SHOOT   = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  // Power/substrate pins carry no logic.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  logic bot_meta_q, bot_s_q;
  logic top_meta_q, top_s_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             bot_en_q, bot_en_d;
  logic             top_en_q, top_en_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;

  logic fb_low;
  logic dead_done;
  logic dead_tmo;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      bot_meta_q <= 1'b0;
      bot_s_q    <= 1'b0;
      top_meta_q <= 1'b0;
      top_s_q    <= 1'b0;
    end else begin
      bot_meta_q <= bot_fb;
      bot_s_q    <= bot_meta_q;
      top_meta_q <= top_fb;
      top_s_q    <= top_meta_q;
    end
  end

  assign fb_low    = !bot_s_q && !top_s_q;
  // Completing the dead time outranks a timeout landing on the same cycle.
  assign dead_done = fb_low && (dcnt_q == DEAD_LAST);
  assign dead_tmo  = (tcnt_q == TMO_LAST) && !dead_done;

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_OFF: begin
        if (en) begin
          state_d = pwm_in ? ST_DEAD_TO_TOP : ST_DEAD_TO_BOT;
        end
      end
      ST_DEAD_TO_BOT: begin
        if (dead_tmo) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_TIMEOUT;
        end else if (!en) begin
          state_d = ST_OFF;
        end else if (pwm_in) begin
          state_d = ST_DEAD_TO_TOP;
        end else if (dead_done) begin
          state_d = ST_BOT_ON;
        end
      end
      ST_DEAD_TO_TOP: begin
        if (dead_tmo) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_TIMEOUT;
        end else if (!en) begin
          state_d = ST_OFF;
        end else if (!pwm_in) begin
          state_d = ST_DEAD_TO_BOT;
        end else if (dead_done) begin
          state_d = ST_TOP_ON;
        end
      end
      ST_BOT_ON: begin
        if (top_s_q) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_SHOOT;
        end else if (!en) begin
          state_d = ST_OFF;
        end else if (pwm_in) begin
          state_d = ST_DEAD_TO_TOP;
        end
      end
      ST_TOP_ON: begin
        if (bot_s_q) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_SHOOT;
        end else if (!en) begin
          state_d = ST_OFF;
        end else if (!pwm_in) begin
          state_d = ST_DEAD_TO_BOT;
        end
      end
      ST_FAULT: begin
        if (clr_fault && !en) begin
          state_d      = ST_OFF;
          fault_code_d = CODE_NONE;
        end
      end
      default: begin
        state_d      = ST_OFF;
        fault_code_d = CODE_NONE;
      end
    endcase
  end

  // Counters only run while staying in the same dead state; any entry starts them from zero.
  always_comb begin
    dcnt_d = '0;
    tcnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_DEAD_TO_BOT) || (state_q == ST_DEAD_TO_TOP))) begin
      dcnt_d = fb_low ? (dcnt_q + CNT_W'(1)) : '0;
      tcnt_d = tcnt_q + CNT_W'(1);
    end
  end

  // Outputs decode the next state so they register together with it.
  always_comb begin
    bot_en_d = (state_d == ST_BOT_ON);
    top_en_d = (state_d == ST_TOP_ON);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q      <= ST_OFF;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      bot_en_q     <= 1'b0;
      top_en_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      tcnt_q       <= tcnt_d;
      bot_en_q     <= bot_en_d;
      top_en_q     <= top_en_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bot_en     = bot_en_q;
  assign top_en     = top_en_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_botsw_fb_sequencer.sv
// Bench for botsw_fb_sequencer: vector table, directed corner sequences and randomized run against a reference model.
module tb_botsw_fb_sequencer;

  localparam int DEAD = 4;
  localparam int TMO  = 32;

  logic       CELCLK, CELRSTN;
  logic       CELV, CELG, SUB;
  logic       en, pwm_in, clr_fault, bot_fb, top_fb;
  logic       bot_en, top_en, fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  botsw_fb_sequencer #(.DEAD_CYC(DEAD), .TIMEOUT_CYC(TMO), .CNT_W(6)) dut (
    .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .en(en), .pwm_in(pwm_in), .clr_fault(clr_fault), .bot_fb(bot_fb), .top_fb(top_fb),
    .bot_en(bot_en), .top_en(top_en), .fault(fault), .fault_code(fault_code), .state(state)
  );

  initial CELCLK = 1'b0;
  always #5 CELCLK = ~CELCLK;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 waiting out dead time, 2 switch conducting, 3 faulted.
  int m_mode, m_side, m_code, low_run, dead_age;
  int b_h0, b_h1, t_h0, t_h1;
  logic bd[4];
  logic td[4];
  bit follow;

  typedef struct {
    logic en, pwm, clr;
    logic [2:0] st;
    logic be, te;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_side = 0; m_code = 0; low_run = 0; dead_age = 0;
    b_h0 = 0; b_h1 = 0; t_h0 = 0; t_h1 = 0;
    for (int i = 0; i < 4; i++) begin
      bd[i] = 1'b0;
      td[i] = 1'b0;
    end
  endtask

  task automatic enter_dead(input int side);
    m_mode = 1; m_side = side; low_run = 0; dead_age = 0;
  endtask

  task automatic go_fault(input int code);
    m_mode = 3; m_code = code;
  endtask

  task automatic model_step();
    int bs, ts, opp;
    bit done;
    bs = b_h1; ts = t_h1;
    b_h1 = b_h0; b_h0 = int'(bot_fb);
    t_h1 = t_h0; t_h0 = int'(top_fb);
    case (m_mode)
      0: if (en) enter_dead(int'(pwm_in));
      1: begin
        low_run  = (bs == 0 && ts == 0) ? low_run + 1 : 0;
        dead_age = dead_age + 1;
        done     = (low_run >= DEAD);
        if (!done && dead_age >= TMO) go_fault(2);
        else if (!en) m_mode = 0;
        else if (int'(pwm_in) != m_side) enter_dead(int'(pwm_in));
        else if (done) m_mode = 2;
      end
      2: begin
        opp = (m_side == 1) ? bs : ts;
        if (opp != 0) go_fault(1);
        else if (!en) m_mode = 0;
        else if (int'(pwm_in) != m_side) enter_dead(int'(pwm_in));
      end
      default: if (clr_fault && !en) begin m_mode = 0; m_code = 0; end
    endcase
  endtask

  function automatic int exp_state();
    case (m_mode)
      0: return 0;
      1: return (m_side == 1) ? 3 : 1;
      2: return (m_side == 1) ? 4 : 2;
      default: return 5;
    endcase
  endfunction

  task automatic cycle();
    model_step();
    @(posedge CELCLK);
    #1;
    chk("model_state", int'(state), exp_state());
    chk("model_bot_en", int'(bot_en), int'(m_mode == 2 && m_side == 0));
    chk("model_top_en", int'(top_en), int'(m_mode == 2 && m_side == 1));
    chk("model_fault", int'(fault), int'(m_mode == 3));
    chk("model_code", int'(fault_code), m_code);
    chk("no_overlap", int'(bot_en && top_en), 0);
    for (int i = 3; i > 0; i--) begin
      bd[i] = bd[i-1];
      td[i] = td[i-1];
    end
    bd[0] = bot_en;
    td[0] = top_en;
    if (follow) begin
      bot_fb = bd[3];
      top_fb = td[3];
    end
  endtask

  task automatic do_reset();
    CELRSTN = 1'b1;
    #1;
    CELRSTN = 1'b0;
    en = 1'b0; pwm_in = 1'b0; clr_fault = 1'b0; bot_fb = 1'b0; top_fb = 1'b0;
    follow = 1'b0;
    model_reset();
    repeat (2) @(posedge CELCLK);
    @(negedge CELCLK);
    CELRSTN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int n;
  bit seen_en;

  initial begin
    CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
    CELRSTN = 1'b1;
    en = 1'b0; pwm_in = 1'b0; clr_fault = 1'b0; bot_fb = 1'b0; top_fb = 1'b0;
    follow = 1'b0;

    // en, pwm, clr -> state, bot_en, top_en after the edge; feedback held low.
    for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
    for (int i = 8; i < 12; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    for (int i = 15; i < 19; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[16].clr = 1'b1;
    tbl[19] = '{1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_bot_en", int'(bot_en), 0);
    chk("rst_top_en", int'(top_en), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_code", int'(fault_code), 0);

    for (int i = 0; i < 21; i++) begin
      en = tbl[i].en; pwm_in = tbl[i].pwm; clr_fault = tbl[i].clr;
      cycle();
      chk($sformatf("tbl%0d_state", i), int'(state), int'(tbl[i].st));
      chk($sformatf("tbl%0d_bot_en", i), int'(bot_en), int'(tbl[i].be));
      chk($sformatf("tbl%0d_top_en", i), int'(top_en), int'(tbl[i].te));
      chk($sformatf("tbl%0d_fault", i), int'(fault), 0);
    end

    // Shoot-through while top is on.
    do_reset();
    en = 1'b1; pwm_in = 1'b1;
    n = 0;
    while (!top_en && n < 20) begin cycle(); n++; end
    chk("shoot_top_on", int'(top_en), 1);
    bot_fb = 1'b1;
    n = 0;
    while (!fault && n < 10) begin cycle(); n++; end
    chk("shoot_latency", n, 3);
    chk("shoot_code", int'(fault_code), 1);
    chk("shoot_top_en", int'(top_en), 0);
    chk("shoot_bot_en", int'(bot_en), 0);
    bot_fb = 1'b0;
    clr_fault = 1'b1;
    repeat (2) cycle();
    chk("clr_ignored_fault", int'(fault), 1);
    chk("clr_ignored_state", int'(state), 5);
    clr_fault = 1'b0; en = 1'b0;
    cycle();
    chk("fault_sticky", int'(fault), 1);
    clr_fault = 1'b1;
    cycle();
    chk("clr_state", int'(state), 0);
    chk("clr_fault", int'(fault), 0);
    chk("clr_code", int'(fault_code), 0);
    clr_fault = 1'b0;

    // Stuck bottom gate during dead time to top.
    do_reset();
    bot_fb = 1'b1; en = 1'b1; pwm_in = 1'b1;
    cycle();
    chk("stuck_entry", int'(state), 3);
    n = 0;
    while (!fault && n < 40) begin cycle(); n++; end
    chk("stuck_latency", n, 32);
    chk("stuck_code", int'(fault_code), 2);
    chk("stuck_top_en", int'(top_en), 0);

    // Dead time completing exactly on the timeout cycle, then one cycle too late.
    do_reset();
    bot_fb = 1'b1; en = 1'b1; pwm_in = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      cycle();
      if (k == 27) bot_fb = 1'b0;
    end
    chk("race_done_state", int'(state), 4);
    chk("race_done_fault", int'(fault), 0);
    do_reset();
    bot_fb = 1'b1; en = 1'b1; pwm_in = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      cycle();
      if (k == 28) bot_fb = 1'b0;
    end
    chk("race_late_state", int'(state), 5);
    chk("race_late_code", int'(fault_code), 2);

    // Commutation with feedback following the enables three cycles late.
    do_reset();
    follow = 1'b1; en = 1'b1; pwm_in = 1'b0;
    n = 0;
    while (!bot_en && n < 20) begin cycle(); n++; end
    chk("comm_bot_on", int'(bot_en), 1);
    repeat (6) cycle();
    pwm_in = 1'b1;
    cycle();
    chk("comm_bot_drop", int'(bot_en), 0);
    n = 1;
    while (!top_en && n < 40) begin cycle(); n++; end
    chk("comm_top_on", int'(top_en), 1);
    chk("comm_dead_min", int'(n >= 9), 1);
    follow = 1'b0;

    // Asynchronous reset between edges while top is on.
    do_reset();
    en = 1'b1; pwm_in = 1'b1;
    n = 0;
    while (!top_en && n < 20) begin cycle(); n++; end
    chk("arst_top_on", int'(top_en), 1);
    #2;
    CELRSTN = 1'b0;
    #1;
    chk("arst_top_en", int'(top_en), 0);
    chk("arst_bot_en", int'(bot_en), 0);
    chk("arst_state", int'(state), 0);
    model_reset();
    repeat (2) @(posedge CELCLK);
    @(negedge CELCLK);
    CELRSTN = 1'b1;
    n = 0; seen_en = 1'b0;
    while (!top_en && n < 20) begin
      cycle(); n++;
      if (bot_en) seen_en = 1'b1;
    end
    chk("arst_restart_latency", n, 5);
    chk("arst_no_bot_en", int'(seen_en), 0);

    // Randomized run: lagging feedback with glitches and periodic stuck windows.
    do_reset();
    follow = 1'b1; en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 8) pwm_in = ~pwm_in;
      en        = ($urandom_range(0, 99) < 92);
      clr_fault = ($urandom_range(0, 99) < 10);
      cycle();
      if ($urandom_range(0, 99) < 3) bot_fb = ~bot_fb;
      if ($urandom_range(0, 99) < 3) top_fb = ~top_fb;
      if ((i % 500) >= 440) top_fb = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
